uart_link_ctrl: RTL and testbench

Controller that sequences the `uart_full_duplex` block on behalf of the rest of the design. On the transmit side it arbitrates between `N_REQ` byte producers using round-robin, launches one frame at a time and holds off new grants until the frame completes. On the receive side it drains every received byte into a small show-ahead FIFO and clears the UART receive flag. It sits between the UART and the processor/peripheral logic, so no client drives `tx_send` or `rx_flag_clr` directly.

---
 rtl/uart_link_ctrl_if.sv | 37 +++
 rtl/uart_link_ctrl.sv | 126 ++++++++++++
 tb/tb_uart_link_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_link_ctrl_if.sv
// Bundle of requester, UART-side and FIFO-read signals around uart_link_ctrl.
// master = the controller, slave = the surrounding logic / UART.
interface uart_link_ctrl_if #(
    parameter int N_REQ    = 2,
    parameter int RX_DEPTH = 4
);
    localparam int CW = $clog2(RX_DEPTH) + 1;

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_send;
    logic               tx_finish;
    logic               rx_flag;
    logic [7:0]         rx_data;
    logic               rx_flag_clr;
    logic               rd_en;
    logic [7:0]         rd_data;
    logic               rx_empty;
    logic [CW-1:0]      rx_count;
    logic               rx_overflow;
    logic               ovf_clr;
    logic               tx_busy;

    modport master (
        input  req_valid, req_data, tx_finish, rx_flag, rx_data, rd_en, ovf_clr,
        output req_ready, tx_data, tx_send, rx_flag_clr, rd_data, rx_empty,
               rx_count, rx_overflow, tx_busy
    );

    modport slave (
        output req_valid, req_data, tx_finish, rx_flag, rx_data, rd_en, ovf_clr,
        input  req_ready, tx_data, tx_send, rx_flag_clr, rd_data, rx_empty,
               rx_count, rx_overflow, tx_busy
    );
endinterface

// File: rtl/uart_link_ctrl.sv
// Sequences a full-duplex UART: round-robin TX arbitration with one frame in
// flight, and RX draining into a show-ahead FIFO with sticky overflow.
module uart_link_ctrl #(
    parameter int N_REQ    = 2,
    parameter int RX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_link_ctrl_if.master bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    state_t           r_state, w_next;
    logic [PW-1:0]    r_rr_ptr;
    logic [7:0]       r_tx_data;
    logic             r_fin_q;
    logic             w_gnt_vld;
    logic [PW-1:0]    w_gnt_idx;
    logic [PW-1:0]    w_idx;
    logic [N_REQ-1:0] w_onehot;
    logic             w_accept;
    logic             w_fin_rise;

    // Grant search starts at rr_ptr; walking k downward leaves the nearest hit.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = PW'((int'(r_rr_ptr) + k) % N_REQ);
            if (bus.req_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    always_comb begin
        w_onehot            = '0;
        w_onehot[w_gnt_idx] = 1'b1;
    end

    assign w_accept   = (r_state == S_IDLE) && w_gnt_vld;
    assign w_fin_rise = bus.tx_finish & ~r_fin_q;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_vld) w_next = S_SEND;
            S_SEND:  w_next = S_WAIT;
            S_WAIT:  if (w_fin_rise) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_tx_data <= 8'h00;
            r_fin_q   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_fin_q <= bus.tx_finish;
            if (w_accept) begin
                r_tx_data <= bus.req_data[{w_gnt_idx, 3'b000} +: 8];
                r_rr_ptr  <= PW'((int'(w_gnt_idx) + 1) % N_REQ);
            end
        end
    end

    assign bus.req_ready = w_accept ? w_onehot : '0;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_send   = (r_state == S_SEND);
    assign bus.tx_busy   = (r_state != S_IDLE);

    logic [7:0]    r_mem [RX_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_clr_pend;
    logic          r_ovf;
    logic          w_full, w_empty, w_capture, w_wr, w_rd, w_ovf_evt;

    assign w_full    = (r_count == CW'(RX_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_rd      = bus.rd_en & ~w_empty;
    // clr_pend masks the flag for the cycle the UART is still clearing it.
    assign w_capture = bus.rx_flag & ~r_clr_pend;
    assign w_wr      = w_capture & (~w_full | w_rd);
    assign w_ovf_evt = w_capture & w_full & ~w_rd;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_clr_pend <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_clr_pend <= w_capture;
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf_evt)        r_ovf <= 1'b1;
            else if (bus.ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign bus.rx_flag_clr = r_clr_pend;
    assign bus.rd_data     = r_mem[r_rd_ptr];
    assign bus.rx_empty    = w_empty;
    assign bus.rx_count    = r_count;
    assign bus.rx_overflow = r_ovf;
endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed bench for uart_link_ctrl: TX arbitration table, RX FIFO sequences
// against a queue model, and reset during WAIT / mid-capture.
module tb_uart_link_ctrl;
    localparam int NR = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_link_ctrl_if #(.N_REQ(NR), .RX_DEPTH(DEPTH)) bus ();

    uart_link_ctrl #(.N_REQ(NR), .RX_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_ready;
        logic [7:0] exp_data;
        bit         drop;
    } tx_vec_t;

    tx_vec_t    tv [9];
    logic [7:0] q [$];
    bit         ovf_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tx_txn(input tx_vec_t v);
        bus.req_valid = v.valid;
        bus.req_data  = {v.d1, v.d0};
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(v.exp_ready));
        chk("busy_idle", 32'(bus.tx_busy), 0);
        @(posedge clk); #1;
        if (v.drop) bus.req_valid = '0;
        chk("tx_send", 32'(bus.tx_send), 1);
        chk("tx_data", 32'(bus.tx_data), 32'(v.exp_data));
        chk("ready_send", 32'(bus.req_ready), 0);
        @(posedge clk); #1;
        chk("send_pulse", 32'(bus.tx_send), 0);
        chk("busy_wait", 32'(bus.tx_busy), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_resend", 32'(bus.tx_send), 0);
        chk("data_held", 32'(bus.tx_data), 32'(v.exp_data));
        bus.tx_finish = 1'b1;
        #1;
        chk("busy_fin", 32'(bus.tx_busy), 1);
        @(posedge clk); #1;
        bus.tx_finish = 1'b0;
        chk("busy_done", 32'(bus.tx_busy), 0);
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit rd, input bit oc);
        bit wr;
        bus.rx_flag = 1'b1;
        bus.rx_data = b;
        bus.rd_en   = rd;
        bus.ovf_clr = oc;
        #1;
        if (rd && q.size() > 0) chk("rd_head", 32'(bus.rd_data), 32'(q[0]));
        wr = (q.size() < DEPTH) || (rd && q.size() > 0);
        if (rd && q.size() > 0) void'(q.pop_front());
        if (wr) q.push_back(b);
        if (!wr)     ovf_m = 1'b1;
        else if (oc) ovf_m = 1'b0;
        @(posedge clk); #1;
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        chk("flag_clr", 32'(bus.rx_flag_clr), 1);
        chk("rx_count", 32'(bus.rx_count), q.size());
        chk("rx_ovf", 32'(bus.rx_overflow), 32'(ovf_m));
        chk("rx_empty", 32'(bus.rx_empty), 32'(q.size() == 0));
        @(posedge clk); #1;
        bus.rx_flag = 1'b0;
        chk("clr_single", 32'(bus.rx_flag_clr), 0);
        chk("pend_guard", 32'(bus.rx_count), q.size());
    endtask

    task automatic rx_pop();
        bus.rd_en = 1'b1;
        #1;
        if (q.size() > 0) chk("pop_data", 32'(bus.rd_data), 32'(q[0]));
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        chk("pop_count", 32'(bus.rx_count), q.size());
        chk("pop_empty", 32'(bus.rx_empty), 32'(q.size() == 0));
    endtask

    initial begin
        tx_vec_t rv;
        tv[0] = '{2'b01, 8'hA5, 8'h00, 2'b01, 8'hA5, 1'b1};
        tv[1] = '{2'b10, 8'h00, 8'h33, 2'b10, 8'h33, 1'b1};
        tv[2] = '{2'b11, 8'h11, 8'h22, 2'b01, 8'h11, 1'b0};
        tv[3] = '{2'b11, 8'h11, 8'h22, 2'b10, 8'h22, 1'b0};
        tv[4] = '{2'b11, 8'h11, 8'h22, 2'b01, 8'h11, 1'b0};
        tv[5] = '{2'b11, 8'h11, 8'h22, 2'b10, 8'h22, 1'b1};
        tv[6] = '{2'b10, 8'h00, 8'h77, 2'b10, 8'h77, 1'b1};
        tv[7] = '{2'b01, 8'h5A, 8'h00, 2'b01, 8'h5A, 1'b1};
        tv[8] = '{2'b01, 8'hC3, 8'h00, 2'b01, 8'hC3, 1'b1};

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_finish = 1'b0;
        bus.rx_flag   = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rd_en     = 1'b0;
        bus.ovf_clr   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.tx_busy), 0);
        chk("rst_send", 32'(bus.tx_send), 0);
        chk("rst_txdata", 32'(bus.tx_data), 0);
        chk("rst_clr", 32'(bus.rx_flag_clr), 0);
        chk("rst_empty", 32'(bus.rx_empty), 1);
        chk("rst_count", 32'(bus.rx_count), 0);
        chk("rst_ovf", 32'(bus.rx_overflow), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) tx_txn(tv[i]);
        bus.req_valid = '0;
        #1;
        chk("ready_none", 32'(bus.req_ready), 0);

        for (int i = 1; i <= 4; i++) rx_byte(8'(i), 1'b0, 1'b0);
        chk("show_ahead", 32'(bus.rd_data), 32'h01);
        rx_byte(8'h55, 1'b0, 1'b0);
        rx_byte(8'h66, 1'b0, 1'b1);
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        ovf_m = 1'b0;
        chk("ovf_clr", 32'(bus.rx_overflow), 0);
        rx_byte(8'h55, 1'b1, 1'b0);
        repeat (4) rx_pop();
        rx_pop();

        rx_byte(8'hA0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) rx_byte(8'hA0 + 8'(i), 1'b1, 1'b0);
        rx_pop();

        // Reset while WAIT and with a capture's clear pulse in flight.
        bus.req_valid = 2'b01;
        bus.req_data  = {8'h00, 8'h99};
        #1;
        chk("wrap_grant", 32'(bus.req_ready), 32'b01);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        bus.rx_flag = 1'b1;
        bus.rx_data = 8'hEE;
        chk("busy_pre_rst", 32'(bus.tx_busy), 1);
        @(posedge clk); #1;
        chk("clr_pre_rst", 32'(bus.rx_flag_clr), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.tx_busy), 0);
        chk("arst_txdata", 32'(bus.tx_data), 0);
        chk("arst_clr", 32'(bus.rx_flag_clr), 0);
        chk("arst_count", 32'(bus.rx_count), 0);
        chk("arst_empty", 32'(bus.rx_empty), 1);
        bus.rx_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_nosend", 32'(bus.tx_send), 0);
        chk("rst_noclr", 32'(bus.rx_flag_clr), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rv = '{2'b11, 8'h12, 8'h34, 2'b01, 8'h12, 1'b1};
        tx_txn(rv);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
